pipe_trace_buffer: RTL

Parametrised capture buffer for CPU diagnostic signals, such as wb_regdata or mem_memdata. It replaces print-only monitoring with an on-chip record of timestamped samples. It supports fill-and-stop capture and circular capture with a trigger and a post-trigger window. Captured samples drain oldest-first over a valid/ready read port, so benches and debug logic can check them after the event.

---
 rtl/pipe_trace_buffer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_trace_buffer.sv
// Timestamped capture buffer: fill-and-stop or circular-with-trigger capture,
// drained oldest-first over a valid/ready read port.
module pipe_trace_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int POST  = 16,
  parameter int TSW   = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           arm,
  input  logic           mode,
  input  logic           trig,
  input  logic           sample_en,
  input  logic [W-1:0]   sample_data,
  input  logic           rd_ready,
  output logic           rd_valid,
  output logic [W-1:0]   rd_data,
  output logic [TSW-1:0] rd_ts,
  output logic [1:0]     state,
  output logic [AW:0]    count,
  output logic           overflow
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CAPTURE  = 2'd1,
    S_POSTTRIG = 2'd2,
    S_READOUT  = 2'd3
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          st, st_n;
  logic [AW-1:0]   wptr, wptr_n, rptr, rptr_n, post_cnt, post_cnt_n;
  logic [AW:0]     count_n, remaining, remaining_n;
  logic            overflow_n, mode_q, mode_n;
  logic [TSW-1:0]  ts;
  logic            wr_en, xfer;

  logic [W-1:0]    mem_data [DEPTH];
  logic [TSW-1:0]  mem_ts   [DEPTH];

  assign state    = st;
  assign rd_valid = (st == S_READOUT) && (remaining != '0);
  assign xfer     = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem_data[rptr] : '0;
  assign rd_ts    = rd_valid ? mem_ts[rptr]   : '0;

  always_comb begin
    st_n        = st;
    wptr_n      = wptr;
    rptr_n      = rptr;
    post_cnt_n  = post_cnt;
    count_n     = count;
    remaining_n = remaining;
    overflow_n  = overflow;
    mode_n      = mode_q;
    wr_en       = 1'b0;

    case (st)
      S_IDLE: begin
        if (arm) begin
          st_n       = S_CAPTURE;
          wptr_n     = '0;
          count_n    = '0;
          overflow_n = 1'b0;
          mode_n     = mode;
        end
      end

      S_CAPTURE, S_POSTTRIG: begin
        if (st == S_CAPTURE && arm) begin
          wptr_n     = '0;
          count_n    = '0;
          overflow_n = 1'b0;
          mode_n     = mode;
        end else begin
          if (sample_en) begin
            wr_en  = 1'b1;
            wptr_n = wptr + 1'b1;
            if (count == FULL) overflow_n = 1'b1;
            else               count_n    = count + 1'b1;
          end
          if (st == S_CAPTURE) begin
            if (!mode_q) begin
              if (sample_en && count == FULL - 1'b1) st_n = S_READOUT;
            end else if (trig) begin
              // the trigger-cycle sample is stored but not counted in the window
              st_n       = S_POSTTRIG;
              post_cnt_n = AW'(POST);
            end
          end else if (sample_en) begin
            post_cnt_n = post_cnt - 1'b1;
            if (post_cnt == AW'(1)) st_n = S_READOUT;
          end
        end
        // once wrapped, the oldest entry sits where the next write would land
        if (st_n == S_READOUT) begin
          rptr_n      = (count_n == FULL) ? wptr_n : '0;
          remaining_n = count_n;
        end
      end

      S_READOUT: begin
        if (xfer) begin
          rptr_n      = rptr + 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == (AW+1)'(1)) st_n = S_IDLE;
        end
      end

      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      post_cnt  <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      mode_q    <= 1'b0;
      ts        <= '0;
    end else begin
      st        <= st_n;
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      post_cnt  <= post_cnt_n;
      count     <= count_n;
      remaining <= remaining_n;
      overflow  <= overflow_n;
      mode_q    <= mode_n;
      ts        <= ts + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_data[wptr] <= sample_data;
      mem_ts[wptr]   <= ts;
    end
  end

endmodule
